// File: rtl/scr1_reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// The counter is sized to hold the larger of the hold and ack-timeout loads.
package scr1_reset_seq_pkg;

    localparam int unsigned MAX_DOMAINS = 8;

    typedef enum logic [2:0] {
        StHold,
        StRelease,
        StWaitAck,
        StRun,
        StSoftHold,
        StSoftWait
    } seq_state_e;

    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned ack_timeout);
        int unsigned max_v;
        max_v = (hold_cycles > ack_timeout) ? hold_cycles : ack_timeout;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/scr1_reset_seq_timer.sv
// Loadable down-counter shared by the hold and ack-timeout phases.
// It saturates at zero; expired_o is high while the count is zero.
module scr1_reset_seq_timer #(
    parameter int unsigned Width  = 5,
    parameter int unsigned RstVal = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= Width'(RstVal);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/scr1_reset_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, releases them in index order waiting
// for each status acknowledge (with timeout), and services per-domain soft resets in RUN.
module scr1_reset_seq_ctrl
    import scr1_reset_seq_pkg::*;
#(
    parameter int unsigned DOMAINS     = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sys_rst_req,
    input  logic [DOMAINS-1:0] dom_rst_req,
    input  logic [DOMAINS-1:0] dom_rst_status,
    output logic [DOMAINS-1:0] dom_rst_n_out,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               timeout_err,
    output logic [2:0]         timeout_dom
);

    localparam int unsigned CntW = cnt_width(HOLD_CYCLES, ACK_TIMEOUT);
    localparam int unsigned IdxW = (DOMAINS > 1) ? $clog2(DOMAINS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DOMAINS - 1);

    if (DOMAINS < 1 || DOMAINS > MAX_DOMAINS) begin : g_bad_domains
        $error("DOMAINS out of range");
    end

    seq_state_e         state_q, state_d;
    logic [IdxW-1:0]    idx_q, idx_d, req_idx;
    logic [DOMAINS-1:0] rst_n_q, rst_n_d;
    logic               busy_q, busy_d, done_q, done_d, terr_q, terr_d;
    logic [2:0]         tdom_q, tdom_d;
    logic               tmr_load, tmr_en, tmr_expired, ack;
    logic [CntW-1:0]    tmr_val;

    scr1_reset_seq_timer #(
        .Width  (CntW),
        .RstVal (HOLD_CYCLES)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    // Lowest requesting domain wins; the rest are dropped.
    always_comb begin
        req_idx = '0;
        for (int i = DOMAINS - 1; i >= 0; i--) begin
            if (dom_rst_req[i]) req_idx = IdxW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rst_n_d  = rst_n_q;
        terr_d   = terr_q;
        tdom_d   = tdom_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        ack      = dom_rst_status[idx_q];

        if (sys_rst_req) begin
            state_d  = StHold;
            idx_d    = '0;
            rst_n_d  = '0;
            terr_d   = 1'b0;
            tdom_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = CntW'(HOLD_CYCLES);
        end else begin
            unique case (state_q)
                StHold, StSoftHold: begin
                    if (tmr_expired) begin
                        rst_n_d[idx_q] = 1'b1;
                        tmr_load       = 1'b1;
                        tmr_val        = CntW'(ACK_TIMEOUT - 1);
                        state_d        = (state_q == StHold) ? StWaitAck : StSoftWait;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                StRelease: begin
                    rst_n_d[idx_q] = 1'b1;
                    tmr_load       = 1'b1;
                    tmr_val        = CntW'(ACK_TIMEOUT - 1);
                    state_d        = StWaitAck;
                end
                StWaitAck, StSoftWait: begin
                    if (ack || tmr_expired) begin
                        // A timed-out domain is treated as acknowledged so the system still comes up.
                        if (!ack) begin
                            terr_d = 1'b1;
                            tdom_d = 3'(idx_q);
                        end
                        if (state_q == StSoftWait || idx_q == LastIdx) begin
                            state_d = StRun;
                        end else begin
                            idx_d   = idx_q + IdxW'(1);
                            state_d = StRelease;
                        end
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                StRun: begin
                    if (dom_rst_req != '0) begin
                        idx_d            = req_idx;
                        rst_n_d[req_idx] = 1'b0;
                        tmr_load         = 1'b1;
                        tmr_val          = CntW'(HOLD_CYCLES - 1);
                        state_d          = StSoftHold;
                    end
                end
                default: state_d = StHold;
            endcase
        end

        busy_d = (state_d != StRun);
        done_d = (state_d == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHold;
            idx_q   <= '0;
            rst_n_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            tdom_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            tdom_q  <= tdom_d;
        end
    end

    assign dom_rst_n_out = rst_n_q;
    assign seq_busy      = busy_q;
    assign seq_done      = done_q;
    assign timeout_err   = terr_q;
    assign timeout_dom   = tdom_q;

endmodule
